// File: rtl/led_switch_io_if.sv
// led_switch_io_if: CPU-side IO bus between the memory/IO routing stage and the LED/switch block.
interface led_switch_io_if;
    logic        iLedCtrl;
    logic        iSwitchCtrl;
    logic [3:0]  iAddressLow;
    logic [31:0] iWriteData;
    logic [15:0] oIoReadData;

    // Routing stage drives selects, offset and store data; it receives load data.
    modport master (
        output iLedCtrl,
        output iSwitchCtrl,
        output iAddressLow,
        output iWriteData,
        input  oIoReadData
    );

    // The peripheral consumes the store/load request and returns load data.
    modport slave (
        input  iLedCtrl,
        input  iSwitchCtrl,
        input  iAddressLow,
        input  iWriteData,
        output oIoReadData
    );
endinterface

// File: rtl/led_switch_io.sv
// led_switch_io: LED register, switch synchroniser/debouncer and sticky change flag behind the CPU IO bus.
module led_switch_io #(
    parameter int DEBOUNCE_CYCLES = 230000
) (
    input  logic                  iClock,
    input  logic                  iReset,
    led_switch_io_if.slave        bus,
    input  logic [23:0]           iSwitchPins,
    output logic [23:0]           oLedPins
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [23:0]   led_q, led_d;
    logic [23:0]   sync1_q, sync2_q;
    logic [23:0]   stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          accept;
    logic          clr;

    // LED field update: offset 0x0 loads the low 16 LEDs, 0x2 the top 8; other offsets leave LEDs alone.
    always_comb begin
        led_d = led_q;
        if (bus.iLedCtrl && bus.iAddressLow == 4'h0) led_d[15:0] = bus.iWriteData[15:0];
        if (bus.iLedCtrl && bus.iAddressLow == 4'h2) led_d[23:16] = bus.iWriteData[7:0];
    end

    // Shared-counter debounce: any mismatch with the accepted value counts, a return to it restarts.
    always_comb begin
        accept   = (sync2_q != stable_q) && (cnt_q == LAST);
        clr      = bus.iSwitchCtrl && bus.iAddressLow == 4'h4;
        cnt_d    = (sync2_q == stable_q || accept) ? '0 : cnt_q + CW'(1);
        stable_d = accept ? sync2_q : stable_q;
        flag_d   = accept ? 1'b1 : (clr ? 1'b0 : flag_q);
    end

    // Load data is combinational so it lands in the same single-cycle load; reads return pre-clear flag.
    always_comb begin
        bus.oIoReadData = !bus.iSwitchCtrl          ? 16'h0000 :
                          bus.iAddressLow == 4'h0   ? stable_q[15:0] :
                          bus.iAddressLow == 4'h2   ? {8'h00, stable_q[23:16]} :
                          bus.iAddressLow == 4'h4   ? {15'h0000, flag_q} :
                                                      16'h0000;
    end

    // State registers; reset clears everything at once so switches re-qualify from zero.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            led_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            sync1_q  <= iSwitchPins;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
        end
    end

    assign oLedPins = led_q;
endmodule

// File: doc/led_switch_io.md
# led_switch_io

Board-side I/O peripheral that sits directly downstream of the CPU's memory/IO routing stage: it consumes the LED and switch chip selects, the low address bits and the store data, and it returns 16-bit switch data for loads. It holds the 24 board LEDs in a register and synchronises and debounces the 24 board switches. It also keeps a sticky "switches changed" flag that software can poll and clear.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 230000: number of consecutive clock edges a new synchronised switch value must persist before it is accepted. Must be ≥1. Counter width is clog2(DEBOUNCE_CYCLES+1).

Ports (one clock; reset is asynchronous and active-high):
- iClock  input  1  CPU clock; all state updates on the rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iLedCtrl  input  1  LED chip select; asserted means an IO store to this block is in progress.
- iSwitchCtrl  input  1  switch chip select; asserted means an IO load from this block is in progress.
- iAddressLow  input  4  bits [3:0] of the data address (register offset).
- iWriteData  input  32  store data.
- oIoReadData  output  16  load data returned toward the register file.
- iSwitchPins  input  24  raw asynchronous switch pins.
- oLedPins  output  24  LED drive, active-high.

## Operation
- Register map by offset (iAddressLow):
  - 0x0: LED[15:0] on write; switches[15:0] on read.
  - 0x2: LED[23:16] from iWriteData[7:0] on write; {8'h00, switches[23:16]} on read.
  - 0x4: read only, returns {15'h0, changeFlag}. Reading it clears the flag.
  - Any other offset: writes are ignored; reads return 16'h0000.
- LED write: on the rising edge with iLedCtrl=1, the selected LED field loads from iWriteData. Bits outside that field hold. iWriteData bits [31:16] are always ignored.
- Switch synchroniser: two flops, sync1 then sync2, 24 bits wide.
- Debouncer: one shared counter and a 24-bit stableSw register. It evaluates on each edge:
  - If sync2 equals stableSw, the counter resets to 0.
  - If they differ and the counter equals DEBOUNCE_CYCLES-1, then stableSw ← sync2, the counter resets to 0, and changeFlag is set.
  - If they differ otherwise, the counter increments.
  - A bounce back to stableSw before the count completes restarts the count.
  - A different non-stable value replacing the pending one does not restart the count. The value sampled on the accepting edge wins.
- changeFlag: cleared on an edge with iSwitchCtrl=1 and offset 0x4. If set and clear happen on the same edge, set wins.
- Read path: oIoReadData is combinational from stableSw/changeFlag and the offset, gated by iSwitchCtrl. It is 16'h0000 whenever iSwitchCtrl=0.
- iLedCtrl and iSwitchCtrl both 1 is illegal upstream. If it occurs, both actions are performed independently.

## Timing
- Reset values: oLedPins=24'h0, sync1=sync2=stableSw=0, counter=0, changeFlag=0, oIoReadData=16'h0000. Reset takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-debounce aborts the count. After release, switch values re-qualify from zero.
- LED write latency: oLedPins reflects a store after the same rising edge on which iLedCtrl=1.
- Read latency: zero cycles (combinational) within the load cycle. This matches the single-cycle datapath.
- Switch latency: a pin change set up before edge E0 is in sync1 after E0 and in sync2 after E1. The first mismatch count happens at E2. stableSw updates at edge E(DEBOUNCE_CYCLES+1), provided the pins stay constant.
- The clear-on-read of changeFlag happens at the end of the load cycle. The load itself returns the pre-clear value.

## Test plan
Simulate with DEBOUNCE_CYCLES=4.
- Reset: assert iReset asynchronously mid-cycle with the LEDs at 24'hFFFFFF. Required: oLedPins=0 immediately, and offset 0x4 reads 0.
- LED fields:
  - Write 32'hABCD1234 at offset 0x0. Required: oLedPins=24'h001234 after the edge.
  - Then write 32'h000000C5 at offset 0x2. Required: oLedPins=24'hC51234.
  - Write at offset 0x6. Required: no change.
- Debounce accept: set pins to 24'h5A00FF before E0. Required: offset 0x0 reads 16'h0000 through E4 and 16'h00FF after E5. Offset 0x2 reads 16'h005A. Offset 0x4 reads 16'h0001.
- Bounce reject: toggle pin 0 high for 3 cycles, then low. Required: stableSw never changes and changeFlag stays 0.
- Flag clear versus set: read offset 0x4 on the same edge that a new value is accepted. Required: the read returns the old flag value and changeFlag=1 afterwards. A subsequent read of 0x4 returns 1, and the read after that returns 0.
- Idle read gating: set iSwitchCtrl=0 with the switches at 24'hFFFFFF. Required: oIoReadData=16'h0000. An invalid offset 0x8 with iSwitchCtrl=1 also returns 16'h0000.
